imm_extender: RTL
=================

# imm_extender

Parametrised immediate-extension stage for the MIPS datapath. It widens an IN_W-bit instruction immediate to OUT_W bits in one of four modes: sign-extend, zero-extend, load-upper, or branch offset (sign-extend and shift left by 2). The result is registered behind a valid/ready handshake with a one-entry skid buffer, so the block can sit between decode and execute in a pipelined core without breaking the ready path. A wrap-around transfer counter supports debug and verification.

## Interface
- IN_W, 16, immediate input width (≥ 2)
- OUT_W, 32, extended output width; constraint OUT_W ≥ IN_W + 2
- CNT_W, 16, width of transfer counter
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  reset, synchronous and active-high
- in_valid  input  1  upstream offers in_imm/in_mode
- in_ready  output  1  block can accept this cycle
- in_imm  input  IN_W  raw immediate
- in_mode  input  2  0=SIGN, 1=ZERO, 2=LUI, 3=BRANCH
- out_valid  output  1  out_data holds a valid result
- out_ready  input  1  downstream consumes when out_valid high
- out_data  output  OUT_W  extended result
- xfer_count  output  CNT_W  number of completed output transfers

## Operation
- Input transfer (IT): in_valid & in_ready at a rising edge. Output transfer (OT): out_valid & out_ready at a rising edge.
- Extension function f(imm, mode), purely combinational on the input side:
  - SIGN: OUT_W-IN_W copies of imm[IN_W-1], then imm.
  - ZERO: zeros, then imm.
  - LUI: out[OUT_W-1 : OUT_W-IN_W] = imm; all lower bits 0.
  - BRANCH: sign-extended value shifted left 2 and truncated to OUT_W; out[1:0] = 0.
- Storage: output register (OR) drives out_data/out_valid. Skid register (SR) holds one extended result plus a full flag. f is applied before storage, so SR stores extended data.
- Per-edge update, in priority order:
  - If OR is empty, or an OT occurs this edge:
    - If SR is full, load OR from SR and clear SR. If an IT also occurs, the new result goes into SR.
    - Else, if an IT occurs, load OR with f(in).
    - Else, clear out_valid.
  - Else (OR full and held): an IT writes f(in) into SR.
- in_ready = !SR_full, taken from a register. It never depends combinationally on out_ready.
- Ordering is strictly FIFO. No result is dropped or duplicated.
- xfer_count increments by 1 on every OT. It wraps from 2^CNT_W−1 to 0.
- Data fields not marked valid are don't-care. out_data holds its value while out_valid is high and out_ready is low.

## Timing
- Reset (synchronous, sampled at an edge) sets:
  - out_valid=0
  - out_data=0
  - SR empty
  - in_ready=1 from the first cycle after reset
  - xfer_count=0
- Reset overrides a simultaneous IT or OT. In-flight data is discarded and not counted.
- Latency: an IT at edge N gives out_valid=1 with the result during the cycle after edge N (1 cycle).
- Throughput: 1 result per cycle while out_ready stays high. SR is never used in that case.
- Backpressure: with out_ready low, at most 2 results are buffered (OR + SR). in_ready falls in the cycle after the second IT.
- Recovery: the first OT after a stall moves SR into OR and raises in_ready in the following cycle.
- Simultaneous IT and OT with SR empty and OR full: OR takes the new result, and out_valid stays high.

## Test plan
- Mode sweep with out_ready=1, reset deasserted. Expected out_data, each one cycle after its IT, and xfer_count=4 at the end:
  - in_imm=16'hF000, SIGN → 32'hFFFFF000
  - 16'h0011, ZERO → 32'h00000011
  - 16'h8310, LUI → 32'h83100000
  - 16'h9999, BRANCH → 32'hFFFE6664
- Back-to-back: 8 consecutive ITs with SIGN, values 16'h0000..16'h0007, out_ready=1 → 8 consecutive valid cycles in order, in_ready constantly 1.
- Backpressure: out_ready=0, offer 16'h8000, 16'h7FFF, 16'h1234 with SIGN.
  - Only 2 accepted; in_ready=0 after the second.
  - Raise out_ready → outputs 32'hFFFF8000, 32'h00007FFF, then 32'h00001234 once accepted. Order preserved, nothing lost.
- Reset mid-operation: with OR and SR both full, assert reset for 1 edge → out_valid=0, out_data=0, in_ready=1, xfer_count=0. The next IT behaves as after power-up.
- Counter wrap: CNT_W=4, 17 OTs → xfer_count reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
- Parameter check: IN_W=8, OUT_W=16. BRANCH with 8'h80 → 16'hFE00. LUI with 8'hA5 → 16'hA500.

Source files
------------

// File: rtl/imm_extender.sv
// -----------------------------------------------------------------------------
// imm_extender
// Immediate-extension stage between decode and execute. Widens an IN_W-bit
// immediate to OUT_W bits (sign, zero, load-upper or branch offset), then
// registers the result behind a valid/ready handshake. A one-entry skid
// register absorbs the result that arrives in the cycle the downstream stalls,
// so in_ready comes straight from a flop and never from out_ready.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   in_valid    upstream offers in_imm / in_mode
//   in_ready    block accepts this cycle (registered: skid register empty)
//   in_imm      raw immediate, IN_W bits
//   in_mode     0 = SIGN, 1 = ZERO, 2 = LUI, 3 = BRANCH
//   out_valid   out_data holds a result
//   out_ready   downstream consumes when out_valid is high
//   out_data    extended result, OUT_W bits
//   xfer_count  wrap-around count of completed output transfers
// -----------------------------------------------------------------------------
module imm_extender #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_imm,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [CNT_W-1:0]  xfer_count
);

  localparam int PAD_W = OUT_W - IN_W;

  localparam logic [1:0] MODE_SIGN   = 2'd0;
  localparam logic [1:0] MODE_ZERO   = 2'd1;
  localparam logic [1:0] MODE_LUI    = 2'd2;
  localparam logic [1:0] MODE_BRANCH = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [OUT_W-1:0] sext_data;
  logic [OUT_W-1:0] ext_data;

  logic             or_valid;
  logic [OUT_W-1:0] or_data;
  logic             sr_full;
  logic [OUT_W-1:0] sr_data;
  logic [CNT_W-1:0] cnt;

  logic             it;
  logic             ot;

  // Extension happens on the input side so both storage slots hold final data.
  assign sext_data = {{PAD_W{in_imm[IN_W-1]}}, in_imm};

  always_comb begin
    ext_data = sext_data;
    case (in_mode)
      MODE_SIGN:   ext_data = sext_data;
      MODE_ZERO:   ext_data = {{PAD_W{1'b0}}, in_imm};
      MODE_LUI:    ext_data = {in_imm, {PAD_W{1'b0}}};
      // Top two sign bits fall off; OUT_W >= IN_W + 2 keeps the value intact.
      MODE_BRANCH: ext_data = {sext_data[OUT_W-3:0], 2'b00};
      default:     ext_data = sext_data;
    endcase
  end

  assign it = in_valid & in_ready;
  assign ot = or_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      or_valid <= 1'b0;
      or_data  <= '0;
      sr_full  <= 1'b0;
      sr_data  <= '0;
      cnt      <= '0;
    end else begin
      if (!or_valid || ot) begin
        if (sr_full) begin
          // Skid entry is older than anything arriving now, so it goes first.
          or_data  <= sr_data;
          or_valid <= 1'b1;
          if (it) begin
            sr_data <= ext_data;
            sr_full <= 1'b1;
          end else begin
            sr_full <= 1'b0;
          end
        end else if (it) begin
          or_data  <= ext_data;
          or_valid <= 1'b1;
        end else begin
          or_valid <= 1'b0;
        end
      end else if (it) begin
        // Output held by downstream: park the new result in the skid slot.
        sr_data <= ext_data;
        sr_full <= 1'b1;
      end

      if (ot) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  assign in_ready   = ~sr_full;
  assign out_valid  = or_valid;
  assign out_data   = or_data;
  assign xfer_count = cnt;

endmodule
